// File: rtl/gp_reg_bank_if.sv
// Bus-side signal bundle for gp_reg_bank: write data, instruction fields, strobes, read port and error flag.
// The datapath drives through the master modport; the register bank attaches to the slave modport.
interface gp_reg_bank_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  logic [WIDTH-1:0] d;
  logic [31:0]      ir;
  logic             gra;
  logic             grb;
  logic             grc;
  logic             rin;
  logic             rout;
  logic             ba_out;
  logic [NREGS-1:0] rin_ext;
  logic             err_clr;
  // bus_valid is a one-cycle qualifier with no back-pressure: bus_out holds
  // read data exactly in cycles where bus_valid=1 and is forced to zero otherwise.
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;
  logic             sel_err;

  modport master (
    output d, ir, gra, grb, grc, rin, rout, ba_out, rin_ext, err_clr,
    input  bus_out, bus_valid, sel_err
  );

  modport slave (
    input  d, ir, gra, grb, grc, rin, rout, ba_out, rin_ext, err_clr,
    output bus_out, bus_valid, sel_err
  );
endinterface

// File: rtl/gp_reg_bank.sv
// General-purpose register bank with integrated Ra/Rb/Rc select encode, registered read port and R0 base-address masking.
// Optional feature macro: GP_REG_BANK_BYPASS_EN (same-cycle read of a register being written returns the new data).
module gp_reg_bank #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 16,
  parameter int SEL_W    = 4,
  parameter int R0_RESET = 0
) (
  input  logic            clk,
  input  logic            clr,
  gp_reg_bank_if.slave    bus
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_bus_out;
  logic             r_bus_valid;
  logic             r_sel_err;

  logic [SEL_W-1:0] w_sel;
  logic             w_hit;
  logic             w_conflict;
  logic [NREGS-1:0] w_we;
  logic [WIDTH-1:0] w_rd_data;

  // Field priority gra > grb > grc; only the low SEL_W bits of each field index the bank.
  always_comb begin
    w_sel = bus.ir[15 +: SEL_W];
    if (bus.gra) begin
      w_sel = bus.ir[23 +: SEL_W];
    end else if (bus.grb) begin
      w_sel = bus.ir[19 +: SEL_W];
    end
  end

  assign w_hit      = bus.gra | bus.grb | bus.grc;
  assign w_conflict = (bus.rin | bus.rout) &
                      ((bus.gra & bus.grb) | (bus.gra & bus.grc) | (bus.grb & bus.grc));

  always_comb begin
    w_we = bus.rin_ext;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rin && w_hit && (w_sel == SEL_W'(i))) begin
        w_we[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = r_regs[w_sel];
`ifdef GP_REG_BANK_BYPASS_EN
    if (w_we[w_sel]) begin
      w_rd_data = bus.d;
    end
`endif
    // Base-address mode masks R0 on the read path only; its storage is untouched.
    if ((w_sel == '0) && bus.ba_out) begin
      w_rd_data = '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == 0) ? WIDTH'(R0_RESET) : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= bus.d;
        end
      end
    end
  end

  // Idle cycles drive zero so the block can share an OR-combined bus.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
    end else if (bus.rout && w_hit) begin
      r_bus_out   <= w_rd_data;
      r_bus_valid <= 1'b1;
    end else begin
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_sel_err <= 1'b0;
    end else if (w_conflict) begin
      r_sel_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  assign bus.bus_out   = r_bus_out;
  assign bus.bus_valid = r_bus_valid;
  assign bus.sel_err   = r_sel_err;

endmodule

// File: tb/tb_gp_reg_bank.sv
// Directed bench for gp_reg_bank: a register-array reference model checked every cycle plus hand-computed literals.
// Build with or without GP_REG_BANK_BYPASS_EN; the model follows the same macro.
module tb_gp_reg_bank;

  localparam int W = 32;
  localparam int N = 16;

  logic clk = 1'b0;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  gp_reg_bank_if #(.WIDTH(W), .NREGS(N)) bus_if ();

  gp_reg_bank #(.WIDTH(W), .NREGS(N), .SEL_W(4), .R0_RESET(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_regs [N];
  logic [W-1:0] m_next [N];
  logic [W-1:0] m_bus;
  logic         m_valid;
  logic         m_err;
  int           m_sel;
  int           m_ngr;
  bit           m_hit;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N; i++) m_regs[i] = '0;
      m_regs[0] = 5;
      m_bus     = '0;
      m_valid   = 1'b0;
      m_err     = 1'b0;
    end else begin
      m_hit = bus_if.gra || bus_if.grb || bus_if.grc;
      m_ngr = int'(bus_if.gra) + int'(bus_if.grb) + int'(bus_if.grc);
      if (bus_if.gra)      m_sel = int'(bus_if.ir[26:23]);
      else if (bus_if.grb) m_sel = int'(bus_if.ir[22:19]);
      else                 m_sel = int'(bus_if.ir[18:15]);
      m_next = m_regs;
      if (bus_if.rin && m_hit) m_next[m_sel] = bus_if.d;
      for (int i = 0; i < N; i++) if (bus_if.rin_ext[i]) m_next[i] = bus_if.d;
      if (bus_if.rout && m_hit) begin
        m_valid = 1'b1;
        if (m_sel == 0 && bus_if.ba_out) m_bus = '0;
`ifdef GP_REG_BANK_BYPASS_EN
        else m_bus = m_next[m_sel];
`else
        else m_bus = m_regs[m_sel];
`endif
      end else begin
        m_valid = 1'b0;
        m_bus   = '0;
      end
      if ((bus_if.rin || bus_if.rout) && m_ngr > 1) m_err = 1'b1;
      else if (bus_if.err_clr) m_err = 1'b0;
      m_regs = m_next;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_bus_out", bus_if.bus_out, m_bus);
      chk("model_bus_valid", W'(bus_if.bus_valid), W'(m_valid));
      chk("model_sel_err", W'(bus_if.sel_err), W'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_ir(input int ra, input int rb, input int rc);
    return {5'b0, 4'(ra), 4'(rb), 4'(rc), 15'b0};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus_if.d       = '0;
    bus_if.ir      = '0;
    bus_if.gra     = 1'b0;
    bus_if.grb     = 1'b0;
    bus_if.grc     = 1'b0;
    bus_if.rin     = 1'b0;
    bus_if.rout    = 1'b0;
    bus_if.ba_out  = 1'b0;
    bus_if.rin_ext = '0;
    bus_if.err_clr = 1'b0;
  endtask

  task automatic wr_a(input int r, input logic [W-1:0] v);
    idle();
    bus_if.ir  = mk_ir(r, 0, 0);
    bus_if.gra = 1'b1;
    bus_if.rin = 1'b1;
    bus_if.d   = v;
    tick();
  endtask

  task automatic rd_a(input int r, input logic ba);
    idle();
    bus_if.ir     = mk_ir(r, 0, 0);
    bus_if.gra    = 1'b1;
    bus_if.rout   = 1'b1;
    bus_if.ba_out = ba;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    clr = 1'b1;
    repeat (2) tick();
    clr = 1'b0;
    chk_en = 1'b1;
    chk("rst_bus_valid", W'(bus_if.bus_valid), '0);
    chk("rst_sel_err", W'(bus_if.sel_err), '0);

    // Reset in the middle of a held read
    wr_a(3, 32'h77);
    rd_a(3, 1'b0);
    chk("pre_rst_read_r3", bus_if.bus_out, 32'h77);
    #2 clr = 1'b1;
    #1;
    chk("async_clr_bus_out", bus_if.bus_out, '0);
    chk("async_clr_valid", W'(bus_if.bus_valid), '0);
    tick();
    clr = 1'b0;
    rd_a(0, 1'b0);
    chk("r0_reset_value", bus_if.bus_out, 32'd5);
    chk("r0_reset_valid", W'(bus_if.bus_valid), 32'd1);
    rd_a(3, 1'b0);
    chk("r3_after_reset", bus_if.bus_out, '0);

    // Encoded write / read, then idle
    wr_a(3, 32'hDEADBEEF);
    rd_a(3, 1'b0);
    chk("enc_read_r3", bus_if.bus_out, 32'hDEADBEEF);
    idle();
    tick();
    chk("idle_bus_out", bus_if.bus_out, '0);
    chk("idle_valid", W'(bus_if.bus_valid), '0);

    // Base-address masking
    wr_a(0, 32'h1234);
    rd_a(0, 1'b1);
    chk("r0_masked", bus_if.bus_out, '0);
    chk("r0_masked_valid", W'(bus_if.bus_valid), 32'd1);
    rd_a(0, 1'b0);
    chk("r0_unmasked", bus_if.bus_out, 32'h1234);
    idle();
    bus_if.ir = mk_ir(0, 1, 0); bus_if.grb = 1'b1; bus_if.rin = 1'b1; bus_if.d = 32'hCAFE;
    tick();
    idle();
    bus_if.ir = mk_ir(0, 0, 1); bus_if.grc = 1'b1; bus_if.rout = 1'b1; bus_if.ba_out = 1'b1;
    tick();
    chk("r1_not_masked", bus_if.bus_out, 32'hCAFE);

    // Priority and sticky select error
    idle();
    bus_if.ir = mk_ir(2, 7, 0); bus_if.gra = 1'b1; bus_if.grb = 1'b1;
    bus_if.rin = 1'b1; bus_if.d = 32'hAA;
    tick();
    chk("conflict_sets_err", W'(bus_if.sel_err), 32'd1);
    idle();
    bus_if.ir = mk_ir(0, 7, 0); bus_if.grb = 1'b1; bus_if.rout = 1'b1;
    tick();
    chk("r7_untouched", bus_if.bus_out, '0);
    rd_a(2, 1'b0);
    chk("r2_priority_write", bus_if.bus_out, 32'hAA);
    chk("err_sticky", W'(bus_if.sel_err), 32'd1);
    idle();
    bus_if.ir = mk_ir(2, 0, 5); bus_if.gra = 1'b1; bus_if.grc = 1'b1;
    bus_if.rout = 1'b1; bus_if.err_clr = 1'b1;
    tick();
    chk("set_beats_clear", W'(bus_if.sel_err), 32'd1);
    chk("conflict_read_ra", bus_if.bus_out, 32'hAA);
    idle();
    bus_if.err_clr = 1'b1;
    tick();
    chk("err_cleared", W'(bus_if.sel_err), '0);

    // Direct loads
    idle();
    bus_if.rin_ext = 16'h0006; bus_if.d = 32'h55;
    tick();
    chk("ext_no_err", W'(bus_if.sel_err), '0);
    rd_a(1, 1'b1);
    chk("ext_r1", bus_if.bus_out, 32'h55);
    rd_a(2, 1'b0);
    chk("ext_r2", bus_if.bus_out, 32'h55);

    // Same-cycle read and write of R4
    wr_a(4, 32'h11);
    idle();
    bus_if.ir = mk_ir(4, 0, 0); bus_if.gra = 1'b1;
    bus_if.rin = 1'b1; bus_if.rout = 1'b1; bus_if.d = 32'h22;
    tick();
`ifdef GP_REG_BANK_BYPASS_EN
    chk("rw_same_bypass", bus_if.bus_out, 32'h22);
`else
    chk("rw_same_old", bus_if.bus_out, 32'h11);
`endif
    rd_a(4, 1'b0);
    chk("r4_updated", bus_if.bus_out, 32'h22);

    // rin/rout with no field strobe: no effect
    idle();
    bus_if.rin = 1'b1; bus_if.rout = 1'b1; bus_if.d = 32'h99; bus_if.ir = mk_ir(4, 4, 4);
    tick();
    chk("nohit_valid", W'(bus_if.bus_valid), '0);
    rd_a(4, 1'b0);
    chk("nohit_r4_kept", bus_if.bus_out, 32'h22);

    // Back-to-back reads with ir/ba changing every cycle
    for (int k = 0; k < 6; k++) begin
      rd_a((k * 5) % 16, 1'(k % 2));
      chk("b2b_valid", W'(bus_if.bus_valid), 32'd1);
    end
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
